helios_link_arbiter: RTL
========================

# helios_link_arbiter

Round-robin, burst-limited arbiter that shares one 64-bit outbound link (the leaf's parent_tx channel) among several 64-bit valid/ready message sources: the local controller and the grid_1/grid_2 forwarding paths. It sits between those sources and the inter-FPGA link. It grants one source at a time, holds the grant for up to BURST_MAX consecutive beats, and registers the winning beat with its source ID into a single-entry output stage.

## Interface
- NUM_REQ, 3, number of requesters (≥2); requester 0 = local controller, 1 = grid_1, 2 = grid_2
- DATA_WIDTH, 64, message width
- BURST_MAX, 4, max consecutive beats granted to one requester while another is waiting (≥1)
- SRC_WIDTH, $clog2(NUM_REQ), source ID width
---
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_data  in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready; at most one bit high
- out_data  out  DATA_WIDTH  registered beat to the link
- out_src  out  SRC_WIDTH  requester index of out_data
- out_valid  out  1  output stage holds a beat
- out_ready  in  1  link accepts the beat

## Operation
- A beat transfers on any side when valid & ready are both high at the rising edge.
- load_en = !out_valid | out_ready. req_ready[i] = grant[i] & load_en. grant is combinational from req_valid, owner, ptr and burst_cnt.
- The FSM has two states:
  - IDLE: no owner. The grant goes to the first valid requester scanning ptr, ptr+1, … (mod NUM_REQ). On the accepted beat: go to OWNED, owner = granted index, burst_cnt = 1.
  - OWNED: the owner keeps the grant while req_valid[owner] = 1 and either burst_cnt < BURST_MAX or no other requester is valid. Each accepted beat increments burst_cnt, saturating at BURST_MAX.
  - Leaving OWNED: when req_valid[owner] drops, or burst_cnt = BURST_MAX with another requester valid, set ptr = owner+1 (mod NUM_REQ). The grant is re-arbitrated as in IDLE in the same cycle, so there are no bubbles. If nothing is valid, go to IDLE.
- The grant never changes while load_en = 0; the arbiter state is frozen during backpressure.
- On an accepted beat, out_data ← req_data[granted], out_src ← granted, out_valid ← 1. If out_ready = 1 and no beat is accepted, out_valid ← 0.
- A requester must hold data stable while valid & !ready. The arbiter does not check this.

## Timing
- Reset values: out_valid 0, out_data 0, out_src 0, req_ready 0 (follows grant; forced 0 while reset_n low), ptr 0, burst_cnt 0, state IDLE.
- Latency is 1 cycle from input accept to out_valid. Throughput is 1 beat/cycle with out_ready held high, including across owner switches.
- Simultaneous drain and load: the register is overwritten with the new beat and out_valid stays 1.
- reset_n asserted mid-burst: the in-flight output beat is dropped and all state returns to its reset value asynchronously. Deassertion is synchronised externally.

## Configuration
- HELIOS_ARB_STATS_EN defined: the block adds
  - input stats_clear (1 bit, synchronous)
  - output grant_count (NUM_REQ*32): accepted beats per requester, saturating at 32'hffffffff
  - output stall_count (32): cycles with out_valid & !out_ready, saturating
  - All counters reset to 0.
- HELIOS_ARB_STATS_EN undefined: these ports and counters do not exist, and arbitration behaviour is identical.

## Structure
- Shared package helios_link_pkg holds:
  - the arbiter state enum (ARB_IDLE, ARB_OWNED)
  - the LINK_DATA_WIDTH = 64 constant
  - the source-ID localparams SRC_LOCAL = 0, SRC_GRID1 = 1, SRC_GRID2 = 2
- One sub-module, helios_rr_pick, is a combinational rotate-priority picker: given valid vector and start index, it returns a one-hot grant and its index. The FSM, burst counter and output register live in the top module.

## Test plan
- Single requester: req 1 streams 10 beats with out_ready = 1 -> 10 beats out on consecutive cycles, out_src = 1, first out_valid one cycle after the first accept.
- Contention: all three valid continuously, BURST_MAX = 4 -> out_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,0… with no idle cycles.
- Lone owner exceeds burst: only req 2 valid for 9 beats -> all 9 granted to req 2 without a break. Then req 0 asserts mid-burst -> req 2 is limited to 4 beats counted from the saturated count, i.e. the switch to req 0 happens on the next beat.
- Backpressure: out_ready = 0 for 5 cycles with req 0 and req 1 valid -> out_data stable, req_ready all 0, grant unchanged; on release the sequence resumes with no beat lost or duplicated.
- Reset mid-burst: reset_n low while OWNED with out_valid = 1 -> out_valid 0 immediately, ptr 0. After release, all valid -> first grant to req 0.
- HELIOS_ARB_STATS_EN: 6 beats from req 1 and 3 stall cycles -> grant_count[1] = 6, stall_count = 3; stats_clear -> all counters 0 on the next cycle.

Source files
------------

// File: rtl/helios_link_pkg.sv
// Shared definitions for the helios link arbiter slice: arbiter state
// encoding, link width and the fixed source-ID assignments.
package helios_link_pkg;

   localparam int LINK_DATA_WIDTH = 64;

   localparam int SRC_LOCAL = 0;
   localparam int SRC_GRID1 = 1;
   localparam int SRC_GRID2 = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_t;

   // Index following idx in a ring of n entries.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/helios_link_arbiter_if.sv
// Requester-side and link-side handshake bundle of the helios link arbiter.
// slave is the arbiter's view, master is the view of whoever drives the
// requesters and consumes the link.
interface helios_link_arbiter_if
   import helios_link_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = LINK_DATA_WIDTH,
   parameter int SRC_WIDTH  = $clog2(NUM_REQ)
);
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [SRC_WIDTH-1:0]          out_src;
   logic                          out_valid;
   logic                          out_ready;

   modport master (
      output req_data, req_valid, out_ready,
      input  req_ready, out_data, out_src, out_valid
   );

   modport slave (
      input  req_data, req_valid, out_ready,
      output req_ready, out_data, out_src, out_valid
   );
endinterface

// File: rtl/helios_rr_pick.sv
// Rotate-priority picker: one-hot grant of the first valid requester found
// scanning from start upwards, wrapping at NUM_REQ.
module helios_rr_pick #(
   parameter int NUM_REQ   = 3,
   parameter int SRC_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   valid,
   input  logic [SRC_WIDTH-1:0] start,
   output logic [NUM_REQ-1:0]   grant,
   output logic [SRC_WIDTH-1:0] idx,
   output logic                 found
);

   int unsigned          cand;
   logic [SRC_WIDTH-1:0] cand_idx;

   // scan start, start+1, ... and keep the first valid hit
   always_comb begin
      grant    = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = 32'(start) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = SRC_WIDTH'(cand);
         if (!found && valid[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            idx             = cand_idx;
         end
      end
   end

endmodule

// File: rtl/helios_link_arbiter.sv
// Round-robin, burst-limited arbiter sharing one outbound link among
// NUM_REQ valid/ready sources, with a single registered output stage.
// Optional statistics counters are built when HELIOS_ARB_STATS_EN is defined.
module helios_link_arbiter
   import helios_link_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = LINK_DATA_WIDTH,
   parameter int BURST_MAX  = 4,
   parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   helios_link_arbiter_if.slave   link
`ifdef HELIOS_ARB_STATS_EN
   ,
   input  logic                   stats_clear,
   output logic [NUM_REQ*32-1:0]  grant_count,
   output logic [31:0]            stall_count
`endif
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   arb_state_t           state_q, state_d;
   logic [SRC_WIDTH-1:0] owner_q, owner_d;
   logic [SRC_WIDTH-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]     burst_q, burst_d;

   logic                 load_en;
   logic                 accept;
   logic                 keep;
   logic                 leaving;
   logic                 others_valid;
   logic [SRC_WIDTH-1:0] owner_inc;
   logic [SRC_WIDTH-1:0] pick_start;
   logic [NUM_REQ-1:0]   pick_grant;
   logic [SRC_WIDTH-1:0] pick_idx;
   logic                 pick_found;
   logic [NUM_REQ-1:0]   grant;
   logic [SRC_WIDTH-1:0] grant_idx;
   logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

   helios_rr_pick #(
      .NUM_REQ   (NUM_REQ),
      .SRC_WIDTH (SRC_WIDTH)
   ) u_pick (
      .valid (link.req_valid),
      .start (pick_start),
      .grant (pick_grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // decide whether the current owner keeps the link this cycle
   always_comb begin
      owner_inc    = SRC_WIDTH'(wrap_inc(32'(owner_q), NUM_REQ));
      others_valid = |(link.req_valid & ~(NUM_REQ'(1) << owner_q));
      keep         = (state_q == ARB_OWNED) && link.req_valid[owner_q] &&
                     ((burst_q < CNT_W'(BURST_MAX)) || !others_valid);
      leaving      = (state_q == ARB_OWNED) && !keep;
      // a leaving owner re-arbitrates from owner+1 in the same cycle (no bubble)
      pick_start   = leaving ? owner_inc : ptr_q;
   end

   // final grant, handshake and source-word selection
   always_comb begin
      grant     = pick_grant;
      grant_idx = pick_idx;
      if (keep) begin
         grant          = '0;
         grant[owner_q] = 1'b1;
         grant_idx      = owner_q;
      end
      load_en        = !link.out_valid || link.out_ready;
      accept         = load_en && (keep || pick_found);
      link.req_ready = grant & {NUM_REQ{load_en && reset_n}};
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_word[i] = link.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // next owner, pointer and burst count; frozen while the output is blocked
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      if (load_en) begin
         if (leaving) ptr_d = owner_inc;
         if (accept) begin
            state_d = ARB_OWNED;
            owner_d = grant_idx;
            if (keep) begin
               burst_d = (burst_q == CNT_W'(BURST_MAX)) ? burst_q : burst_q + 1'b1;
            end else begin
               burst_d = CNT_W'(1);
            end
         end else if (leaving) begin
            state_d = ARB_IDLE;
            burst_d = '0;
         end
      end
   end

   // arbiter state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
      end
   end

   // single-entry output stage; a new beat overwrites a draining one
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         link.out_valid <= 1'b0;
         link.out_data  <= '0;
         link.out_src   <= '0;
      end else if (accept) begin
         link.out_valid <= 1'b1;
         link.out_data  <= req_word[grant_idx];
         link.out_src   <= grant_idx;
      end else if (link.out_ready) begin
         link.out_valid <= 1'b0;
      end
   end

`ifdef HELIOS_ARB_STATS_EN
   logic [31:0] gcnt_q [NUM_REQ];

   // saturating per-requester beat counters and output stall counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
         stall_count <= '0;
      end else if (stats_clear) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
         stall_count <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept && (grant_idx == SRC_WIDTH'(i)) && (gcnt_q[i] != '1))
               gcnt_q[i] <= gcnt_q[i] + 1'b1;
         end
         if (link.out_valid && !link.out_ready && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

   // flatten the per-requester counters onto the output bus
   always_comb begin
      grant_count = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_count[i*32 +: 32] = gcnt_q[i];
   end
`else
   // statistics counters are not built in this configuration
`endif

endmodule
